move_controller: RTL and testbench
==================================

# move_controller

Sequences the chess board datapath feeding the LCD renderer. Owns the cursor, the piece selection, both colours' packed location and alive vectors, and the side to move. Turns debounced button pulses into a select/move/capture sequence and commits each board update only during vertical blanking, so a frame never shows a half-applied move. Sits between the button debouncers and the LCD block.

## Interface
- INIT_LOC_W, 96'h20928B30D38F0070460850C4, white start locations
- INIT_LOC_B, 96'hC31CB3D35DB7E3FE7EEBDEFC, black start locations
- INIT_CURSOR, 6'o04, cursor after reset (row 0, col 4)
- clk12  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- btn_up, btn_down, btn_left, btn_right, btn_enter, btn_esc  in  1 each  single-cycle pulses, already debounced
- vsync  in  1  LCD VSYNC; high means vertical blanking
- cursor  out  6  {row[2:0], col[2:0]}
- sel_active  out  1  a piece is selected; drives the LCD enter_pressed highlight
- location_vectors_w, location_vectors_b  out  96 each  piece k at [6k+5 -: 6] = {row, col}
- alive_vectors_w, alive_vectors_b  out  16 each  bit k = piece k on board
- player  out  1  1 = white to move
- busy  out  1  high in SCAN_SRC, SCAN_DST, COMMIT
- err  out  1  one-cycle pulse on a rejected action
- move_done  out  1  one-cycle pulse on the commit cycle
- game_over  out  1  sticky; set when a king is captured

## Operation
- Piece indices: 0 king, 1 queen, 2–3 bishops, 4–5 knights, 6–7 rooks, 8–15 pawns.
- Reset values:
  - cursor = INIT_CURSOR; loc = INIT_LOC_*; alive = 16'hFFFF each; player = 1.
  - sel_active, busy, err, move_done, game_over = 0; state IDLE.
- Cursor movement:
  - up/down = row ±1; right/left = col ±1; modulo 8 (row 7 + up → row 0; col 0 + left → col 7).
  - Active in IDLE and SELECTED only.
- Same-cycle button priority: esc > enter > up > down > left > right. Lower-priority pulses in that cycle are dropped.
- FSM states:
  - IDLE: enter → SCAN_SRC.
  - SCAN_SRC: visits index 0..15, one per cycle, over the mover's vectors. A match is an alive piece whose location equals cursor; record it as sel_idx.
    - Hit → SELECTED, sel_active = 1.
    - Miss → IDLE, err pulse.
  - SELECTED:
    - esc → IDLE, sel_active = 0.
    - enter with cursor == source → IDLE (deselect).
    - any other enter → SCAN_DST, dest latched = cursor.
  - SCAN_DST: 16 cycles, scanning both colours in parallel.
    - Own alive piece at dest → SELECTED, err pulse.
    - Otherwise record whether an opponent alive piece is at dest, and its cap_idx → COMMIT.
  - COMMIT: wait for vsync = 1. In that cycle, a single atomic write:
    - mover loc[sel_idx] = dest;
    - on a capture, opponent alive[cap_idx] = 0, and game_over = 1 if cap_idx == 0;
    - player toggled; move_done pulse; sel_active = 0; → IDLE.
- Dead pieces keep their last location and are skipped in every scan.
- No chess-rule legality checks here; only own-occupancy is rejected.
- game_over = 1: all buttons ignored until reset.
- Buttons during busy are ignored; the cursor does not move.

## Timing
- All outputs are registered.
- SCAN_SRC and SCAN_DST each take exactly 16 cycles, plus 1 decision cycle.
- COMMIT latency runs from entry to the first cycle with vsync high. If vsync is already high on entry, commit happens on the next cycle.
- err and move_done are high for exactly one cycle.
- reset in any state, including mid-scan and COMMIT, restores every reset value on the next edge.

## Structure
- Shared package chess_pkg:
  - piece index constants;
  - INIT_LOC_W / INIT_LOC_B;
  - FSM state enum;
  - row/col field-extract helpers.
  The LCD renderer also uses this package.
- One sub-module: piece_scanner.
  - Inputs: index counter, two 96-bit vectors, two alive vectors, target square.
  - Outputs: own_hit, opp_hit, hit_idx.
  - Instanced once, shared by both scan states.

## Test plan
- Reset, then idle 100 cycles → cursor 6'o04, player 1, alive both 16'hFFFF, loc equal to INIT values, all pulses 0.
- Wrap-around: cursor 6'o04, left ×5 → 6'o07; down ×1 → 6'o77.
- Quiet move: up, enter, wait for sel_active = 1, up ×2, enter, hold vsync low 1000 cycles.
  - During the hold: no change.
  - Raise vsync: location_vectors_w[71:66] = 6'o34, player = 0, move_done pulse.
- Own-block: enter at 6'o00 (rook selected), up to 6'o10, enter → err pulse, stays SELECTED, vectors unchanged.
- Capture: 1.e2-e4, 1…d7-d5, 2.e4xd5 → alive_vectors_b = 16'hEFFF, location_vectors_w[71:66] = 6'o43, player = 0.
- Rejects and reset:
  - enter on empty 6'o34 at reset → err pulse, sel_active = 0.
  - reset asserted mid-SCAN_DST → all reset values next cycle.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess board definitions: piece indices, start positions, FSM states and
// square-field helpers. Also used by the LCD renderer.
package chess_pkg;

    localparam int unsigned NumPieces = 16;
    localparam int unsigned LocW      = 6;

    // Piece index map within a colour's packed vectors
    localparam logic [3:0] PieceKing    = 4'd0;
    localparam logic [3:0] PieceQueen   = 4'd1;
    localparam logic [3:0] PieceBishop0 = 4'd2;
    localparam logic [3:0] PieceBishop1 = 4'd3;
    localparam logic [3:0] PieceKnight0 = 4'd4;
    localparam logic [3:0] PieceKnight1 = 4'd5;
    localparam logic [3:0] PieceRook0   = 4'd6;
    localparam logic [3:0] PieceRook1   = 4'd7;
    localparam logic [3:0] PiecePawn0   = 4'd8;

    localparam logic [95:0] INIT_LOC_W  = 96'h20928B30D38F0070460850C4;
    localparam logic [95:0] INIT_LOC_B  = 96'hC31CB3D35DB7E3FE7EEBDEFC;
    localparam logic [5:0]  INIT_CURSOR = 6'o04;

    typedef enum logic [2:0] {
        StIdle,
        StScanSrc,
        StSelected,
        StScanDst,
        StCommit
    } state_e;

    function automatic logic [2:0] loc_row(input logic [5:0] loc);
        return loc[5:3];
    endfunction

    function automatic logic [2:0] loc_col(input logic [5:0] loc);
        return loc[2:0];
    endfunction

    // Square of piece idx inside a packed 16 x 6-bit location vector
    function automatic logic [5:0] loc_at(input logic [95:0] vec, input logic [3:0] idx);
        return vec[6*idx +: 6];
    endfunction

endpackage

// File: rtl/piece_scanner.sv
// Single-index occupancy probe: checks piece idx of both colours against a target square.
module piece_scanner (
    input  logic [3:0]  idx,
    input  logic [95:0] own_loc,
    input  logic [95:0] opp_loc,
    input  logic [15:0] own_alive,
    input  logic [15:0] opp_alive,
    input  logic [5:0]  target,
    output logic        own_hit,
    output logic        opp_hit,
    output logic [3:0]  hit_idx
);
    import chess_pkg::*;

    // Dead pieces keep a stale square, so the alive bit gates every match
    always_comb begin
        own_hit = own_alive[idx] && (loc_at(own_loc, idx) == target);
        opp_hit = opp_alive[idx] && (loc_at(opp_loc, idx) == target);
        hit_idx = idx;
    end

endmodule

// File: rtl/move_controller.sv
// Board sequencer: cursor, select/move/capture FSM, and vblank-aligned board commits.
module move_controller #(
    parameter logic [95:0] INIT_LOC_W  = chess_pkg::INIT_LOC_W,
    parameter logic [95:0] INIT_LOC_B  = chess_pkg::INIT_LOC_B,
    parameter logic [5:0]  INIT_CURSOR = chess_pkg::INIT_CURSOR
) (
    input  logic        clk12,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_enter,
    input  logic        btn_esc,
    input  logic        vsync,
    output logic [5:0]  cursor,
    output logic        sel_active,
    output logic [95:0] location_vectors_w,
    output logic [95:0] location_vectors_b,
    output logic [15:0] alive_vectors_w,
    output logic [15:0] alive_vectors_b,
    output logic        player,
    output logic        busy,
    output logic        err,
    output logic        move_done,
    output logic        game_over
);
    import chess_pkg::*;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [5:0]  cursor_q, src_q, dest_q;
    logic [3:0]  sel_idx_q, cap_idx_q;
    logic        found_q, own_blk_q, cap_q;
    logic [95:0] loc_w_q, loc_b_q;
    logic [15:0] alive_w_q, alive_b_q;
    logic        player_q, sel_active_q, busy_q, err_q, move_done_q, game_over_q;

    logic [95:0] own_loc, opp_loc;
    logic [15:0] own_alive, opp_alive;
    logic [5:0]  scan_target, cursor_nxt;
    logic        own_hit, opp_hit;
    logic [3:0]  hit_idx;

    // Mover/opponent views of the board and the square under test
    always_comb begin
        own_loc     = player_q ? loc_w_q : loc_b_q;
        opp_loc     = player_q ? loc_b_q : loc_w_q;
        own_alive   = player_q ? alive_w_q : alive_b_q;
        opp_alive   = player_q ? alive_b_q : alive_w_q;
        scan_target = (state_q == StScanDst) ? dest_q : cursor_q;
    end

    // Cursor step for the highest-priority direction button, wrapping modulo 8
    always_comb begin
        cursor_nxt = cursor_q;
        if (btn_up) begin
            cursor_nxt = {loc_row(cursor_q) + 3'd1, loc_col(cursor_q)};
        end else if (btn_down) begin
            cursor_nxt = {loc_row(cursor_q) - 3'd1, loc_col(cursor_q)};
        end else if (btn_left) begin
            cursor_nxt = {loc_row(cursor_q), loc_col(cursor_q) - 3'd1};
        end else if (btn_right) begin
            cursor_nxt = {loc_row(cursor_q), loc_col(cursor_q) + 3'd1};
        end
    end

    piece_scanner u_scanner (
        .idx       (cnt_q[3:0]),
        .own_loc   (own_loc),
        .opp_loc   (opp_loc),
        .own_alive (own_alive),
        .opp_alive (opp_alive),
        .target    (scan_target),
        .own_hit   (own_hit),
        .opp_hit   (opp_hit),
        .hit_idx   (hit_idx)
    );

    // Control FSM and board state; cnt_q[4] marks the decision cycle after 16 probes
    always_ff @(posedge clk12) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            cursor_q     <= INIT_CURSOR;
            src_q        <= '0;
            dest_q       <= '0;
            sel_idx_q    <= '0;
            cap_idx_q    <= '0;
            found_q      <= 1'b0;
            own_blk_q    <= 1'b0;
            cap_q        <= 1'b0;
            loc_w_q      <= INIT_LOC_W;
            loc_b_q      <= INIT_LOC_B;
            alive_w_q    <= 16'hFFFF;
            alive_b_q    <= 16'hFFFF;
            player_q     <= 1'b1;
            sel_active_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            move_done_q  <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            err_q       <= 1'b0;
            move_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!game_over_q && !btn_esc) begin
                        if (btn_enter) begin
                            state_q <= StScanSrc;
                            cnt_q   <= '0;
                            found_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            cursor_q <= cursor_nxt;
                        end
                    end
                end
                StScanSrc: begin
                    if (!cnt_q[4]) begin
                        cnt_q <= cnt_q + 5'd1;
                        if (own_hit && !found_q) begin
                            found_q   <= 1'b1;
                            sel_idx_q <= hit_idx;
                            src_q     <= cursor_q;
                        end
                    end else begin
                        busy_q <= 1'b0;
                        if (found_q) begin
                            state_q      <= StSelected;
                            sel_active_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            err_q   <= 1'b1;
                        end
                    end
                end
                StSelected: begin
                    if (btn_esc) begin
                        state_q      <= StIdle;
                        sel_active_q <= 1'b0;
                    end else if (btn_enter) begin
                        if (cursor_q == src_q) begin
                            state_q      <= StIdle;
                            sel_active_q <= 1'b0;
                        end else begin
                            state_q   <= StScanDst;
                            dest_q    <= cursor_q;
                            cnt_q     <= '0;
                            own_blk_q <= 1'b0;
                            cap_q     <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                    end else begin
                        cursor_q <= cursor_nxt;
                    end
                end
                StScanDst: begin
                    if (!cnt_q[4]) begin
                        cnt_q <= cnt_q + 5'd1;
                        if (own_hit) begin
                            own_blk_q <= 1'b1;
                        end
                        if (opp_hit) begin
                            cap_q     <= 1'b1;
                            cap_idx_q <= hit_idx;
                        end
                    end else if (own_blk_q) begin
                        state_q <= StSelected;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    // Whole move lands in one vblank cycle so no frame sees it half done
                    if (vsync) begin
                        if (player_q) begin
                            loc_w_q[6*sel_idx_q +: 6] <= dest_q;
                            if (cap_q) alive_b_q[cap_idx_q] <= 1'b0;
                        end else begin
                            loc_b_q[6*sel_idx_q +: 6] <= dest_q;
                            if (cap_q) alive_w_q[cap_idx_q] <= 1'b0;
                        end
                        if (cap_q && cap_idx_q == PieceKing) game_over_q <= 1'b1;
                        player_q     <= ~player_q;
                        move_done_q  <= 1'b1;
                        sel_active_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cursor             = cursor_q;
    assign sel_active         = sel_active_q;
    assign location_vectors_w = loc_w_q;
    assign location_vectors_b = loc_b_q;
    assign alive_vectors_w    = alive_w_q;
    assign alive_vectors_b    = alive_b_q;
    assign player             = player_q;
    assign busy               = busy_q;
    assign err                = err_q;
    assign move_done          = move_done_q;
    assign game_over          = game_over_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller with a board model and commit scoreboard.
module tb_move_controller;

    localparam logic [95:0] LW0 = 96'h20928B30D38F0070460850C4;
    localparam logic [95:0] LB0 = 96'hC31CB3D35DB7E3FE7EEBDEFC;

    logic        clk12 = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
    logic        btn_enter = 0, btn_esc = 0, vsync = 0;
    logic [5:0]  cursor;
    logic        sel_active, player, busy, err, move_done, game_over;
    logic [95:0] location_vectors_w, location_vectors_b;
    logic [15:0] alive_vectors_w, alive_vectors_b;

    typedef struct packed {
        logic [95:0] lw;
        logic [95:0] lb;
        logic [15:0] aw;
        logic [15:0] ab;
        logic        player;
        logic        go;
    } exp_t;

    exp_t        sb_q[$];
    logic [95:0] m_lw, m_lb;
    logic [15:0] m_aw, m_ab;
    logic        m_player, m_go;
    logic [5:0]  m_cur;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk12 = ~clk12;

    move_controller dut (
        .clk12              (clk12),
        .reset              (reset),
        .btn_up             (btn_up),
        .btn_down           (btn_down),
        .btn_left           (btn_left),
        .btn_right          (btn_right),
        .btn_enter          (btn_enter),
        .btn_esc            (btn_esc),
        .vsync              (vsync),
        .cursor             (cursor),
        .sel_active         (sel_active),
        .location_vectors_w (location_vectors_w),
        .location_vectors_b (location_vectors_b),
        .alive_vectors_w    (alive_vectors_w),
        .alive_vectors_b    (alive_vectors_b),
        .player             (player),
        .busy               (busy),
        .err                (err),
        .move_done          (move_done),
        .game_over          (game_over)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk12);
    endtask

    task automatic model_init();
        m_lw = LW0; m_lb = LB0; m_aw = 16'hFFFF; m_ab = 16'hFFFF;
        m_player = 1'b1; m_go = 1'b0; m_cur = 6'o04;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_init();
    endtask

    // 0 up, 1 down, 2 left, 3 right, 4 enter, 5 esc
    task automatic pulse(input int which);
        case (which)
            0: btn_up = 1'b1;
            1: btn_down = 1'b1;
            2: btn_left = 1'b1;
            3: btn_right = 1'b1;
            4: btn_enter = 1'b1;
            default: btn_esc = 1'b1;
        endcase
        tick();
        {btn_up, btn_down, btn_left, btn_right, btn_enter, btn_esc} = '0;
    endtask

    task automatic nav_to(input logic [5:0] tgt);
        while (m_cur[5:3] != tgt[5:3]) begin
            pulse(0);
            m_cur[5:3] = m_cur[5:3] + 3'd1;
        end
        while (m_cur[2:0] != tgt[2:0]) begin
            pulse(3);
            m_cur[2:0] = m_cur[2:0] + 3'd1;
        end
        check("nav_cursor", cursor, tgt);
    endtask

    task automatic wait_sel(input string tag, input int want_lat);
        int k = 0;
        while (sel_active !== 1'b1 && k < 40) begin tick(); k++; end
        check({tag, "_sel"}, sel_active, 1);
        if (want_lat > 0) check({tag, "_sel_latency"}, k, want_lat);
    endtask

    task automatic wait_err(input string tag, input int want_lat);
        int k = 0;
        while (err !== 1'b1 && k < 40) begin tick(); k++; end
        check({tag, "_err_latency"}, k, want_lat);
        tick();
        check({tag, "_err_width"}, err, 0);
    endtask

    // Model update for one move of the side to move; result queued for the commit
    task automatic push_move(input int idx, input logic [5:0] dst, input logic cap,
                             input int cap_idx);
        if (m_player) begin
            m_lw[6*idx +: 6] = dst;
            if (cap) m_ab[cap_idx] = 1'b0;
        end else begin
            m_lb[6*idx +: 6] = dst;
            if (cap) m_aw[cap_idx] = 1'b0;
        end
        if (cap && cap_idx == 0) m_go = 1'b1;
        m_player = ~m_player;
        sb_q.push_back('{lw: m_lw, lb: m_lb, aw: m_aw, ab: m_ab, player: m_player, go: m_go});
    endtask

    task automatic do_move(input string tag, input logic [5:0] src, input logic [5:0] dst,
                           input int idx, input logic cap, input int cap_idx);
        nav_to(src);
        pulse(4);
        wait_sel(tag, 0);
        nav_to(dst);
        push_move(idx, dst, cap, cap_idx);
        pulse(4);
    endtask

    task automatic wait_commit(input string tag, input int want_lat);
        exp_t e;
        int   k = 0;
        while (move_done !== 1'b1 && k < 2000) begin tick(); k++; end
        check({tag, "_commit_latency"}, k, want_lat);
        e = sb_q.pop_front();
        check({tag, "_loc_w"}, location_vectors_w, e.lw);
        check({tag, "_loc_b"}, location_vectors_b, e.lb);
        check({tag, "_alive_w"}, alive_vectors_w, e.aw);
        check({tag, "_alive_b"}, alive_vectors_b, e.ab);
        check({tag, "_player"}, player, e.player);
        check({tag, "_game_over"}, game_over, e.go);
        check({tag, "_sel_clear"}, sel_active, 0);
        tick();
        check({tag, "_done_width"}, move_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required $finish");
        $fatal(1);
    end

    initial begin
        int stray;
        int bad;
        stray = 0;
        bad = 0;
        model_init();
        repeat (3) tick();
        reset = 1'b0;

        // Reset values after a long idle stretch
        repeat (100) begin
            tick();
            if (err || move_done || busy || sel_active) stray++;
        end
        check("rst_cursor", cursor, 6'o04);
        check("rst_player", player, 1);
        check("rst_alive_w", alive_vectors_w, 16'hFFFF);
        check("rst_alive_b", alive_vectors_b, 16'hFFFF);
        check("rst_loc_w", location_vectors_w, LW0);
        check("rst_loc_b", location_vectors_b, LB0);
        check("rst_game_over", game_over, 0);
        check("rst_idle_pulses", stray, 0);

        // Cursor wrap-around
        repeat (5) pulse(2);
        check("wrap_left", cursor, 6'o07);
        pulse(1);
        check("wrap_down", cursor, 6'o77);

        // Enter on an empty square is rejected; buttons ignored while scanning
        do_reset();
        nav_to(6'o34);
        pulse(4);
        check("scan_busy", busy, 1);
        pulse(0);
        check("busy_cursor_frozen", cursor, 6'o34);
        wait_err("empty", 16);
        check("empty_sel", sel_active, 0);
        check("empty_busy", busy, 0);

        // Quiet move e2-e4 held off by vsync
        do_reset();
        nav_to(6'o14);
        pulse(4);
        wait_sel("e2", 17);
        nav_to(6'o34);
        push_move(11, 6'o34, 1'b0, 0);
        pulse(4);
        repeat (1000) begin
            tick();
            if (move_done || location_vectors_w !== LW0 || player !== 1'b1) bad++;
        end
        check("hold_no_change", bad, 0);
        check("hold_busy", busy, 1);
        vsync = 1'b1;
        wait_commit("e2e4", 1);
        check("e2e4_pawn", location_vectors_w[71:66], 6'o34);

        // d7-d5, then e4xd5 with vsync already high
        do_move("d7d5", 6'o63, 6'o43, 12, 1'b0, 0);
        wait_commit("d7d5", 18);
        do_move("exd5", 6'o34, 6'o43, 11, 1'b1, 12);
        wait_commit("exd5", 18);
        check("exd5_alive_b", alive_vectors_b, 16'hEFFF);
        check("exd5_pawn", location_vectors_w[71:66], 6'o43);
        check("exd5_player", player, 0);

        // Black queen takes the white king; everything locks until reset
        do_move("qxk", 6'o73, 6'o04, 1, 1'b1, 0);
        wait_commit("qxk", 18);
        pulse(0);
        check("go_cursor_frozen", cursor, 6'o04);
        pulse(4);
        tick();
        check("go_no_scan", busy, 0);

        // Own-occupancy reject keeps the selection
        do_reset();
        vsync = 1'b0;
        nav_to(6'o00);
        pulse(4);
        wait_sel("rook", 17);
        nav_to(6'o10);
        pulse(4);
        wait_err("own_block", 17);
        check("own_block_sel", sel_active, 1);
        check("own_block_loc_w", location_vectors_w, LW0);
        pulse(5);
        check("esc_deselect", sel_active, 0);

        // Reset in the middle of a destination scan
        nav_to(6'o10);
        pulse(4);
        wait_sel("pawn", 17);
        nav_to(6'o20);
        pulse(4);
        repeat (5) tick();
        check("mid_scan_busy", busy, 1);
        do_reset();
        check("mid_rst_cursor", cursor, 6'o04);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sel", sel_active, 0);
        check("mid_rst_player", player, 1);
        check("mid_rst_loc_w", location_vectors_w, LW0);
        check("mid_rst_alive_b", alive_vectors_b, 16'hFFFF);
        check("mid_rst_pulses", {err, move_done, game_over}, 3'b000);
        stray = 0;
        repeat (30) begin
            tick();
            if (busy || move_done || err) stray++;
        end
        check("mid_rst_quiet", stray, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
